// File: rtl/mac_pe_vec.sv
// mac_pe_vec: signed fixed-point multiply-accumulate PE with a local operand RAM.
// A run streams `len` A-operands against peram[0..len-1] through a 3-stage
// pipeline (operand register, multiply, accumulate) and emits one result strobe.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   din, addr, we         peram write port (honoured only while idle)
//   start, len, accum     run request; accum=1 continues from the last result
//   ain, ain_valid        streamed A-operand with valid
//   ain_ready             PE accepts a beat this cycle
//   busy                  run in progress
//   dvalid, dout          one-cycle result strobe and held result
//   ovf                   sticky signed overflow for the current run
module mac_pe_vec #(
    parameter int unsigned L_RAM_SIZE = 6,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ACC_W      = 40
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_W-1:0]     din,
    input  logic [L_RAM_SIZE-1:0] addr,
    input  logic                  we,
    input  logic                  start,
    input  logic [L_RAM_SIZE:0]   len,
    input  logic                  accum,
    input  logic [DATA_W-1:0]     ain,
    input  logic                  ain_valid,
    output logic                  ain_ready,
    output logic                  busy,
    output logic                  dvalid,
    output logic [ACC_W-1:0]      dout,
    output logic                  ovf
);

    localparam int unsigned DEPTH  = 1 << L_RAM_SIZE;
    localparam int unsigned LEN_W  = L_RAM_SIZE + 1;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [DATA_W-1:0] peram_q [DEPTH];

    logic [1:0]               state_q, state_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]        a_s1_q, a_s1_d;
    logic [DATA_W-1:0]        b_s1_q, b_s1_d;
    logic                     v1_q, v1_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     v2_q, v2_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic                     ovf_q, ovf_d;
    logic [ACC_W-1:0]         dout_q, dout_d;
    logic                     dvalid_q, dvalid_d;
    logic                     busy_q, busy_d;
    logic                     ain_ready_q, ain_ready_d;

    logic                     accept_c;
    logic                     len_ok_c;
    logic                     ram_we_c;
    logic [LEN_W-1:0]         cnt_inc_c;
    logic [ACC_W-1:0]         prod_ext_c;
    logic [ACC_W-1:0]         sum_c;
    logic                     ovf_hit_c;

    // Handshake, run-request qualification and accumulator datapath helpers
    always_comb begin
        accept_c   = ain_valid && ain_ready_q;
        len_ok_c   = (len != '0) && (len <= MAX_LEN);
        ram_we_c   = we && (state_q == S_IDLE) && !areset;
        cnt_inc_c  = cnt_q + LEN_W'(1);
        prod_ext_c = ACC_W'(prod_q);
        sum_c      = acc_q + prod_ext_c;
        // Equal operand signs with a differing result sign is signed overflow
        ovf_hit_c  = (acc_q[ACC_W-1] == prod_ext_c[ACC_W-1]) &&
                     (sum_c[ACC_W-1] != acc_q[ACC_W-1]);
    end

    // Next-state, pipeline and output logic
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;

        // Pipeline advances every cycle; only issue into stage 1 is gated
        v1_d   = accept_c;
        a_s1_d = accept_c ? ain : a_s1_q;
        b_s1_d = accept_c ? peram_q[cnt_q[L_RAM_SIZE-1:0]] : b_s1_q;
        v2_d   = v1_q;
        prod_d = PROD_W'($signed(a_s1_q)) * PROD_W'($signed(b_s1_q));

        if (v2_q) begin
            acc_d = sum_c;
            if (ovf_hit_c) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && len_ok_c) begin
                    len_d   = len;
                    cnt_d   = '0;
                    acc_d   = accum ? acc_q : '0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept_c) begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Last product has been accumulated once both stages are empty
                if (!v1_q && !v2_q) begin
                    dvalid_d = 1'b1;
                    dout_d   = acc_q;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        ain_ready_d = (state_d == S_RUN);
    end

    // State and pipeline registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            a_s1_q      <= '0;
            b_s1_q      <= '0;
            v1_q        <= 1'b0;
            prod_q      <= '0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            ain_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            a_s1_q      <= a_s1_d;
            b_s1_q      <= b_s1_d;
            v1_q        <= v1_d;
            prod_q      <= prod_d;
            v2_q        <= v2_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
            busy_q      <= busy_d;
            ain_ready_q <= ain_ready_d;
        end
    end

    // Operand RAM; contents survive reset
    always_ff @(posedge aclk) begin
        if (ram_we_c) begin
            peram_q[addr] <= din;
        end
    end

    assign ain_ready = ain_ready_q;
    assign busy      = busy_q;
    assign dvalid    = dvalid_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_pe_vec.sv
// tb_mac_pe_vec: randomized, model-checked bench for mac_pe_vec.
// Drives a default-parameter instance and a DATA_W=8/ACC_W=16 instance for the
// wrap/overflow corner; expected results come from a plain-arithmetic dot-product model.
module tb_mac_pe_vec;

    localparam int unsigned LR = 6;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 40;
    localparam longint ACC_MAX = (longint'(1) <<< 39) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< 39);
    localparam longint ACC_MOD = longint'(1) <<< 40;

    logic          aclk;
    logic          areset;
    logic [DW-1:0] din;
    logic [LR-1:0] addr;
    logic          we;
    logic          start;
    logic [LR:0]   len;
    logic          accum;
    logic [DW-1:0] ain;
    logic          ain_valid;
    logic          ain_ready;
    logic          busy;
    logic          dvalid;
    logic [AW-1:0] dout;
    logic          ovf;

    logic [7:0]    s8_din;
    logic [LR-1:0] s8_addr;
    logic          s8_we;
    logic          s8_start;
    logic [LR:0]   s8_len;
    logic          s8_accum;
    logic [7:0]    s8_ain;
    logic          s8_ain_valid;
    logic          s8_ain_ready;
    logic          s8_busy;
    logic          s8_dvalid;
    logic [15:0]   s8_dout;
    logic          s8_ovf;

    int checks   = 0;
    int failures = 0;
    int run_id   = 0;

    longint        m_acc;
    logic [DW-1:0] mem     [64];
    logic [DW-1:0] ain_vec [64];
    bit            pat     [7] = '{1, 0, 0, 1, 1, 0, 1};

    mac_pe_vec #(.L_RAM_SIZE(LR), .DATA_W(DW), .ACC_W(AW)) u_dut (
        .aclk(aclk), .areset(areset), .din(din), .addr(addr), .we(we),
        .start(start), .len(len), .accum(accum), .ain(ain), .ain_valid(ain_valid),
        .ain_ready(ain_ready), .busy(busy), .dvalid(dvalid), .dout(dout), .ovf(ovf)
    );

    mac_pe_vec #(.L_RAM_SIZE(LR), .DATA_W(8), .ACC_W(16)) u_dut8 (
        .aclk(aclk), .areset(areset), .din(s8_din), .addr(s8_addr), .we(s8_we),
        .start(s8_start), .len(s8_len), .accum(s8_accum), .ain(s8_ain),
        .ain_valid(s8_ain_valid), .ain_ready(s8_ain_ready), .busy(s8_busy),
        .dvalid(s8_dvalid), .dout(s8_dout), .ovf(s8_ovf)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_ram(input int a, input logic [DW-1:0] d);
        we   = 1'b1;
        addr = LR'(a);
        din  = d;
        tick();
        we   = 1'b0;
        mem[a] = d;
    endtask

    // Issue one run, stream beats per mode (0 continuous, 1 random gaps, 2 fixed gap
    // pattern) and compare against the model. quick returns in the dvalid cycle.
    task automatic do_run(input int n, input bit acc_in, input int mode,
                          input bit quick, input bit wr_busy);
        longint        e;
        longint        s;
        bit            eo;
        logic [AW-1:0] ed;
        int            acc_cnt;
        int            dv_cnt;
        int            dv_edge;
        int            edges;
        int            step;
        int            post;
        bit            rdy_ok;
        bit            v;
        bit            acc_now;
        logic [AW-1:0] got_dout;
        logic          got_ovf;
        logic          got_busy;

        run_id++;
        e  = acc_in ? m_acc : 0;
        eo = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = e + longint'($signed(mem[i])) * longint'($signed(ain_vec[i]));
            if (s > ACC_MAX) begin
                eo = 1'b1;
                s  = s - ACC_MOD;
            end else if (s < ACC_MIN) begin
                eo = 1'b1;
                s  = s + ACC_MOD;
            end
            e = s;
        end
        ed = e[AW-1:0];

        start     = 1'b1;
        len       = (LR+1)'(n);
        accum     = acc_in;
        ain_valid = 1'b0;
        tick();
        start = 1'b0;

        acc_cnt = 0; dv_cnt = 0; dv_edge = -1; edges = 0; step = 0; post = 0;
        rdy_ok = 1'b1; got_dout = '0; got_ovf = 1'b0; got_busy = 1'b0;
        while (edges < 300) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 3) != 0);
                default: v = (step < 7) ? pat[step] : 1'b1;
            endcase
            step++;
            ain_valid = v;
            ain       = (acc_cnt < n) ? ain_vec[acc_cnt] : DW'($urandom);
            we        = wr_busy && (dv_cnt == 0);
            addr      = '0;
            din       = DW'(99);
            if (acc_cnt < n && ain_ready !== 1'b1) rdy_ok = 1'b0;
            acc_now = v && (ain_ready === 1'b1);
            tick();
            edges++;
            if (acc_now) acc_cnt++;
            if (dvalid === 1'b1) begin
                dv_cnt++;
                if (dv_edge < 0) begin
                    dv_edge  = edges;
                    got_dout = dout;
                    got_ovf  = ovf;
                    got_busy = busy;
                end
            end
            if (dv_cnt > 0) begin
                if (quick) break;
                post++;
                if (post > 3) break;
            end
        end
        ain_valid = 1'b0;
        we        = 1'b0;

        check_eq($sformatf("r%0d_dvalid_count", run_id), 64'(dv_cnt), 64'd1);
        check_eq($sformatf("r%0d_dout", run_id), got_dout, ed);
        check_eq($sformatf("r%0d_ovf", run_id), got_ovf, eo);
        check_eq($sformatf("r%0d_busy_at_dvalid", run_id), got_busy, 1'b0);
        check_eq($sformatf("r%0d_beats", run_id), 64'(acc_cnt), 64'(n));
        check_eq($sformatf("r%0d_ready_during_run", run_id), rdy_ok, 1'b1);
        if (mode == 0)
            check_eq($sformatf("r%0d_latency", run_id), 64'(dv_edge), 64'(n + 3));
        if (!quick) begin
            check_eq($sformatf("r%0d_dout_hold", run_id), dout, ed);
            check_eq($sformatf("r%0d_busy_after", run_id), busy, 1'b0);
            check_eq($sformatf("r%0d_ready_after", run_id), ain_ready, 1'b0);
        end
        m_acc = e;
    endtask

    task automatic bad_start(input int n);
        int dv;
        start = 1'b1;
        len   = (LR+1)'(n);
        accum = 1'b0;
        tick();
        start = 1'b0;
        check_eq($sformatf("badlen%0d_busy", n), busy, 1'b0);
        check_eq($sformatf("badlen%0d_ready", n), ain_ready, 1'b0);
        dv = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dvalid === 1'b1) dv++;
        end
        check_eq($sformatf("badlen%0d_no_dvalid", n), 64'(dv), 64'd0);
    endtask

    initial begin
        bit          seen;
        logic [15:0] g16;
        logic        go;
        int          dv;

        areset = 1'b1; din = '0; addr = '0; we = 1'b0; start = 1'b0; len = '0;
        accum = 1'b0; ain = '0; ain_valid = 1'b0;
        s8_din = '0; s8_addr = '0; s8_we = 1'b0; s8_start = 1'b0; s8_len = '0;
        s8_accum = 1'b0; s8_ain = '0; s8_ain_valid = 1'b0;
        m_acc = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            ain_vec[i] = '0;
        end
        repeat (3) tick();
        areset = 1'b0;

        check_eq("rst_ain_ready", ain_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_dvalid", dvalid, 1'b0);
        check_eq("rst_dout", dout, '0);
        check_eq("rst_ovf", ovf, 1'b0);
        check_eq("rst_s8_dout", s8_dout, '0);

        // Basic dot product followed by a back-to-back accumulating run
        for (int i = 0; i < 4; i++) write_ram(i, DW'(i + 1));
        for (int i = 0; i < 4; i++) ain_vec[i] = DW'(i + 5);
        do_run(4, 1'b0, 0, 1'b1, 1'b0);
        ain_vec[0] = DW'(1);
        ain_vec[1] = DW'(1);
        do_run(2, 1'b1, 0, 1'b0, 1'b0);

        // Gapped stream, then writes while busy must be dropped
        for (int i = 0; i < 4; i++) ain_vec[i] = DW'(i + 5);
        do_run(4, 1'b0, 2, 1'b0, 1'b0);
        do_run(4, 1'b0, 0, 1'b0, 1'b1);
        do_run(4, 1'b0, 0, 1'b0, 1'b0);

        // Out-of-range lengths are ignored
        bad_start(0);
        bad_start(65);

        // Reset after two beats of a run
        start = 1'b1; len = 7'd4; accum = 1'b0;
        tick();
        start = 1'b0; ain_valid = 1'b1; ain = DW'(5);
        tick();
        ain = DW'(6);
        tick();
        areset = 1'b1; ain = DW'(7);
        tick();
        areset = 1'b0; ain_valid = 1'b0;
        check_eq("mrst_dvalid", dvalid, 1'b0);
        check_eq("mrst_dout", dout, '0);
        check_eq("mrst_ready", ain_ready, 1'b0);
        check_eq("mrst_busy", busy, 1'b0);
        dv = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dvalid === 1'b1) dv++;
        end
        check_eq("mrst_no_dvalid", 64'(dv), 64'd0);
        m_acc = 0;
        do_run(4, 1'b1, 0, 1'b0, 1'b0);

        // Narrow instance: wrapping product sum and sticky overflow
        s8_we = 1'b1; s8_addr = '0; s8_din = 8'h80;
        tick();
        s8_addr = LR'(1);
        tick();
        s8_we = 1'b0;
        s8_start = 1'b1; s8_len = 7'd2; s8_accum = 1'b0;
        tick();
        s8_start = 1'b0; s8_ain = 8'h80; s8_ain_valid = 1'b1;
        tick();
        tick();
        s8_ain_valid = 1'b0;
        seen = 1'b0; g16 = '0; go = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (s8_dvalid === 1'b1) begin
                seen = 1'b1; g16 = s8_dout; go = s8_ovf;
            end
        end
        check_eq("s8_dvalid_seen", seen, 1'b1);
        check_eq("s8_wrap_dout", g16, 16'h8000);
        check_eq("s8_ovf_set", go, 1'b1);
        s8_we = 1'b1; s8_addr = '0; s8_din = 8'h03;
        tick();
        s8_we = 1'b0;
        s8_start = 1'b1; s8_len = 7'd1; s8_accum = 1'b0;
        tick();
        s8_start = 1'b0;
        check_eq("s8_ovf_cleared_at_start", s8_ovf, 1'b0);
        s8_ain = 8'h02; s8_ain_valid = 1'b1;
        tick();
        s8_ain_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (s8_dvalid === 1'b1) begin
                seen = 1'b1; g16 = s8_dout; go = s8_ovf;
            end
        end
        check_eq("s8_second_dvalid", seen, 1'b1);
        check_eq("s8_second_dout", g16, 16'h0006);
        check_eq("s8_second_ovf", go, 1'b0);

        // Randomized operands, lengths, accumulate mode and stream gaps
        for (int i = 0; i < 64; i++) write_ram(i, DW'($urandom));
        for (int r = 0; r < 20; r++) begin
            int n;
            n = (r == 0) ? 64 : (r == 1) ? 1 : int'($urandom_range(1, 64));
            for (int i = 0; i < 64; i++) ain_vec[i] = DW'($urandom);
            do_run(n, bit'($urandom_range(0, 1)), 1, 1'b0, 1'b0);
        end

        // Chain full-length runs of (-2^15)^2 until the 40-bit accumulator overflows
        for (int i = 0; i < 64; i++) begin
            write_ram(i, 16'h8000);
            ain_vec[i] = 16'h8000;
        end
        for (int r = 0; r < 9; r++) do_run(64, (r != 0), 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
